// File: rtl/uart_core_if.sv
// uart_core_if: register-file side bundle of the UART engine.
//   THR    tx holding word (only [7:0] used)
//   UCR    control word: [0]TXEN [1]RXEN [2]PEN [3]PODD [6]RXIE [7]TXIE [15:8]DIV
//   thr_wr 1-clk pulse, THR was just written
//   rbr_rd 1-clk pulse, RBR was just read
//   RBR    {8'h00, last received byte}
//   USR    status: [0]THRE [1]TEMT [2]RDR [3]OE [4]PE [5]FE [6]TXBUSY
//   irq    (RDR&RXIE) | (THRE&TXIE)
// master = register file, slave = uart_core.
interface uart_core_if;
  logic [15:0] THR;
  logic [15:0] UCR;
  logic        thr_wr;
  logic        rbr_rd;
  logic [15:0] RBR;
  logic [15:0] USR;
  logic        irq;

  modport master (output THR, UCR, thr_wr, rbr_rd, input RBR, USR, irq);
  modport slave  (input THR, UCR, thr_wr, rbr_rd, output RBR, USR, irq);
endinterface

// File: rtl/uart_core.sv
// uart_core: serial UART engine behind the peripheral register file.
//   clk     system clock
//   Ireset2 asynchronous active-high reset
//   rxd     serial input, idle high, asynchronous to clk
//   txd     serial output, idle high
//   bus     uart_core_if.slave: THR/UCR/thr_wr/rbr_rd in, RBR/USR/irq out
// Frame: start, 8 data LSB first, optional parity (even, or odd when PODD), stop.
// Bit period is OVS*(DIV+1) clk.
module uart_core #(
  parameter int unsigned OVS     = 16,
  parameter int unsigned SYNC_FF = 2
) (
  input  logic       clk,
  input  logic       Ireset2,
  input  logic       rxd,
  output logic       txd,
  uart_core_if.slave bus
);
  localparam int unsigned CntW = 16;
  localparam int unsigned OvsW = $clog2(OVS);

  typedef enum logic [2:0] {TxIdle, TxStart, TxData, TxParity, TxStop} tx_state_e;
  typedef enum logic [2:0] {RxIdle, RxStart, RxData, RxParity, RxStop} rx_state_e;

  logic       w_txen, w_rxen, w_pen, w_podd, w_rxie, w_txie;
  logic [7:0] w_div;
  logic       w_unused;
  assign w_txen   = bus.UCR[0];
  assign w_rxen   = bus.UCR[1];
  assign w_pen    = bus.UCR[2];
  assign w_podd   = bus.UCR[3];
  assign w_rxie   = bus.UCR[6];
  assign w_txie   = bus.UCR[7];
  assign w_div    = bus.UCR[15:8];
  assign w_unused = ^{bus.THR[15:8], bus.UCR[5:4]};

  // ---------------- transmitter ----------------
  tx_state_e       r_tx_state, w_tx_state_nxt;
  logic [7:0]      r_hold, w_hold_nxt, r_tx_sh, w_tx_sh_nxt;
  logic [2:0]      r_tx_idx, w_tx_idx_nxt;
  logic            r_thre, w_thre_nxt, r_tx_busy, w_tx_busy_nxt;
  logic            r_tx_par, w_tx_par_nxt, r_tx_pen, w_tx_pen_nxt;
  logic            r_txd, w_txd_nxt, w_tx_load, w_tx_bit_end;
  logic [CntW-1:0] r_tx_cnt, w_tx_cnt_nxt, r_tx_len, w_tx_len_nxt, w_tx_len_new;

  // Bit length is latched at each bit start so a DIV write lands on a bit boundary.
  assign w_tx_len_new = CntW'(OVS * (32'(w_div) + 32'd1));
  assign w_tx_bit_end = (r_tx_cnt == r_tx_len - CntW'(1));

  always_comb begin
    w_tx_state_nxt = r_tx_state;
    w_hold_nxt     = r_hold;
    w_tx_sh_nxt    = r_tx_sh;
    w_tx_idx_nxt   = r_tx_idx;
    w_thre_nxt     = r_thre;
    w_tx_busy_nxt  = r_tx_busy;
    w_tx_par_nxt   = r_tx_par;
    w_tx_pen_nxt   = r_tx_pen;
    w_tx_cnt_nxt   = r_tx_cnt + CntW'(1);
    w_tx_len_nxt   = r_tx_len;
    w_tx_load      = 1'b0;
    w_txd_nxt      = 1'b1;
    unique case (r_tx_state)
      TxIdle: begin
        w_tx_cnt_nxt = '0;
        w_tx_load    = !r_thre && w_txen;
      end
      TxStart: begin
        w_txd_nxt = 1'b0;
        if (w_tx_bit_end) w_tx_state_nxt = TxData;
      end
      TxData: begin
        w_txd_nxt = r_tx_sh[0];
        if (w_tx_bit_end) begin
          w_tx_sh_nxt  = {1'b0, r_tx_sh[7:1]};
          w_tx_idx_nxt = r_tx_idx + 3'd1;
          if (r_tx_idx == 3'd7) w_tx_state_nxt = r_tx_pen ? TxParity : TxStop;
        end
      end
      TxParity: begin
        w_txd_nxt = r_tx_par;
        if (w_tx_bit_end) w_tx_state_nxt = TxStop;
      end
      TxStop: begin
        if (w_tx_bit_end) begin
          // Holding word waiting: chain straight into the next start bit.
          if (!r_thre && w_txen) begin
            w_tx_load = 1'b1;
          end else begin
            w_tx_state_nxt = TxIdle;
            w_tx_busy_nxt  = 1'b0;
          end
        end
      end
      default: w_tx_state_nxt = TxIdle;
    endcase
    if (w_tx_bit_end && r_tx_state != TxIdle) begin
      w_tx_cnt_nxt = '0;
      w_tx_len_nxt = w_tx_len_new;
    end
    if (w_tx_load) begin
      w_tx_state_nxt = TxStart;
      w_tx_sh_nxt    = r_hold;
      w_tx_idx_nxt   = '0;
      w_tx_par_nxt   = (^r_hold) ^ w_podd;
      w_tx_pen_nxt   = w_pen;
      w_thre_nxt     = 1'b1;
      w_tx_busy_nxt  = 1'b1;
      w_tx_cnt_nxt   = '0;
      w_tx_len_nxt   = w_tx_len_new;
    end
    // A write while the holding register is full is dropped.
    if (bus.thr_wr && r_thre) begin
      w_hold_nxt = bus.THR[7:0];
      w_thre_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge Ireset2) begin
    if (Ireset2) begin
      r_tx_state <= TxIdle;
      r_hold     <= '0;
      r_tx_sh    <= '0;
      r_tx_idx   <= '0;
      r_thre     <= 1'b1;
      r_tx_busy  <= 1'b0;
      r_tx_par   <= 1'b0;
      r_tx_pen   <= 1'b0;
      r_tx_cnt   <= '0;
      r_tx_len   <= '0;
      r_txd      <= 1'b1;
    end else begin
      r_tx_state <= w_tx_state_nxt;
      r_hold     <= w_hold_nxt;
      r_tx_sh    <= w_tx_sh_nxt;
      r_tx_idx   <= w_tx_idx_nxt;
      r_thre     <= w_thre_nxt;
      r_tx_busy  <= w_tx_busy_nxt;
      r_tx_par   <= w_tx_par_nxt;
      r_tx_pen   <= w_tx_pen_nxt;
      r_tx_cnt   <= w_tx_cnt_nxt;
      r_tx_len   <= w_tx_len_nxt;
      r_txd      <= w_txd_nxt;
    end
  end

  // ---------------- receiver ----------------
  rx_state_e       r_rx_state, w_rx_state_nxt;
  logic [SYNC_FF-1:0] r_sync;
  logic            r_rx_prev, w_rx_in, w_tick, w_rx_half, w_rx_full, w_rx_done;
  logic [7:0]      r_rx_pre, w_rx_pre_nxt, r_rx_sh, w_rx_sh_nxt, r_rbr, w_rbr_nxt;
  logic [OvsW-1:0] r_rx_ovs, w_rx_ovs_nxt;
  logic [2:0]      r_rx_idx, w_rx_idx_nxt;
  logic            r_rx_perr, w_rx_perr_nxt;
  logic            r_rdr, w_rdr_nxt, r_oe, w_oe_nxt, r_pe, w_pe_nxt, r_fe, w_fe_nxt;
  logic            r_irq, w_irq_nxt;

  assign w_rx_in      = r_sync[SYNC_FF-1];
  assign w_tick       = (r_rx_pre >= w_div);
  assign w_rx_pre_nxt = w_tick ? 8'd0 : r_rx_pre + 8'd1;
  assign w_rx_half    = w_tick && (r_rx_ovs == OvsW'(OVS / 2 - 1));
  assign w_rx_full    = w_tick && (r_rx_ovs == OvsW'(OVS - 1));

  always_comb begin
    w_rx_state_nxt = r_rx_state;
    w_rx_ovs_nxt   = w_tick ? r_rx_ovs + OvsW'(1) : r_rx_ovs;
    w_rx_sh_nxt    = r_rx_sh;
    w_rx_idx_nxt   = r_rx_idx;
    w_rx_perr_nxt  = r_rx_perr;
    w_rx_done      = 1'b0;
    unique case (r_rx_state)
      RxIdle: begin
        w_rx_ovs_nxt = '0;
        if (r_rx_prev && !w_rx_in) w_rx_state_nxt = RxStart;
      end
      RxStart: begin
        // Mid-start check rejects short glitches.
        if (w_rx_half) begin
          w_rx_ovs_nxt   = '0;
          w_rx_idx_nxt   = '0;
          w_rx_perr_nxt  = 1'b0;
          w_rx_state_nxt = w_rx_in ? RxIdle : RxData;
        end
      end
      RxData: begin
        if (w_rx_full) begin
          w_rx_ovs_nxt = '0;
          w_rx_sh_nxt  = {w_rx_in, r_rx_sh[7:1]};
          w_rx_idx_nxt = r_rx_idx + 3'd1;
          if (r_rx_idx == 3'd7) w_rx_state_nxt = w_pen ? RxParity : RxStop;
        end
      end
      RxParity: begin
        if (w_rx_full) begin
          w_rx_ovs_nxt   = '0;
          w_rx_perr_nxt  = w_rx_in ^ (^r_rx_sh) ^ w_podd;
          w_rx_state_nxt = RxStop;
        end
      end
      RxStop: begin
        if (w_rx_full) begin
          w_rx_done      = 1'b1;
          w_rx_state_nxt = RxIdle;
        end
      end
      default: w_rx_state_nxt = RxIdle;
    endcase
    if (!w_rxen) begin
      w_rx_state_nxt = RxIdle;
      w_rx_done      = 1'b0;
    end
  end

  always_comb begin
    w_rbr_nxt = r_rbr;
    w_rdr_nxt = r_rdr && !bus.rbr_rd;
    w_oe_nxt  = r_oe && !bus.rbr_rd;
    w_pe_nxt  = r_pe && !bus.rbr_rd;
    w_fe_nxt  = r_fe && !bus.rbr_rd;
    // A completing byte wins over a simultaneous read.
    if (w_rx_done) begin
      w_rbr_nxt = r_rx_sh;
      w_rdr_nxt = 1'b1;
      w_oe_nxt  = w_oe_nxt || (r_rdr && !bus.rbr_rd);
      w_pe_nxt  = w_pe_nxt || r_rx_perr;
      w_fe_nxt  = w_fe_nxt || !w_rx_in;
    end
    w_irq_nxt = (w_rdr_nxt && w_rxie) || (w_thre_nxt && w_txie);
  end

  always_ff @(posedge clk or posedge Ireset2) begin
    if (Ireset2) begin
      r_sync     <= '1;
      r_rx_prev  <= 1'b1;
      r_rx_state <= RxIdle;
      r_rx_pre   <= '0;
      r_rx_ovs   <= '0;
      r_rx_sh    <= '0;
      r_rx_idx   <= '0;
      r_rx_perr  <= 1'b0;
      r_rbr      <= '0;
      r_rdr      <= 1'b0;
      r_oe       <= 1'b0;
      r_pe       <= 1'b0;
      r_fe       <= 1'b0;
      r_irq      <= 1'b0;
    end else begin
      r_sync     <= {r_sync[SYNC_FF-2:0], rxd};
      r_rx_prev  <= w_rx_in;
      r_rx_state <= w_rx_state_nxt;
      r_rx_pre   <= w_rx_pre_nxt;
      r_rx_ovs   <= w_rx_ovs_nxt;
      r_rx_sh    <= w_rx_sh_nxt;
      r_rx_idx   <= w_rx_idx_nxt;
      r_rx_perr  <= w_rx_perr_nxt;
      r_rbr      <= w_rbr_nxt;
      r_rdr      <= w_rdr_nxt;
      r_oe       <= w_oe_nxt;
      r_pe       <= w_pe_nxt;
      r_fe       <= w_fe_nxt;
      r_irq      <= w_irq_nxt;
    end
  end

  assign txd     = r_txd;
  assign bus.RBR = {8'h00, r_rbr};
  assign bus.USR = {9'h000, r_tx_busy, r_fe, r_pe, r_oe, r_rdr, r_thre & ~r_tx_busy, r_thre};
  assign bus.irq = r_irq;
endmodule

// File: tb/tb_uart_core.sv
// tb_uart_core: self-checking bench for uart_core.
module tb_uart_core;
  logic clk = 1'b0;
  logic Ireset2;
  logic txd, rxd, rx_drv, loop;

  always #5 clk = ~clk;

  uart_core_if u_if ();
  assign rxd = loop ? txd : rx_drv;

  uart_core #(.OVS(16), .SYNC_FF(2)) u_dut (
    .clk     (clk),
    .Ireset2 (Ireset2),
    .rxd     (rxd),
    .txd     (txd),
    .bus     (u_if)
  );

  typedef struct {
    logic [7:0]  data;
    logic [7:0]  div;
    logic        pen;
    logic        podd;
    logic        lpbk;
    logic        bad_par;
    logic        bad_stop;
    logic [15:0] exp_rbr;
    logic [3:0]  exp_flags;  // {FE, PE, OE, RDR}
  } vec_t;

  typedef struct {
    logic [15:0] rbr;
    logic [3:0]  flags;
  } exp_t;

  vec_t vecs[6];
  exp_t sb[$];
  int   n_chk = 0;
  int   n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
  endtask

  function automatic logic frame_bit(input logic [7:0] d, input int b);
    if (b == 0) return 1'b0;
    if (b <= 8) return d[b-1];
    return 1'b1;
  endfunction

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic thr_write(input logic [7:0] d);
    u_if.THR    = {8'h00, d};
    u_if.thr_wr = 1'b1;
    @(negedge clk);
    u_if.thr_wr = 1'b0;
  endtask

  task automatic send_rx(input logic [7:0] d, input int div, input logic pen, input logic podd,
                         input logic bad_par, input logic bad_stop);
    int t;
    t = 16 * (div + 1);
    rx_drv = 1'b0;
    cycles(t);
    for (int b = 0; b < 8; b++) begin
      rx_drv = d[b];
      cycles(t);
    end
    if (pen) begin
      rx_drv = (^d) ^ podd ^ bad_par;
      cycles(t);
    end
    rx_drv = !bad_stop;
    cycles(t);
    rx_drv = 1'b1;
    cycles(2 * t);
  endtask

  // Pops the scoreboard when RDR rises, then reads RBR and checks the flags clear.
  task automatic check_rx(input string name, input int budget);
    exp_t e;
    int   n;
    n = 0;
    while (u_if.USR[2] !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    e = sb.pop_front();
    if (u_if.USR[2] !== 1'b1) begin
      chk({name, "_rdr_timeout"}, 32'(n), 32'(budget + 1));
      return;
    end
    chk({name, "_rbr"}, 32'(u_if.RBR), 32'(e.rbr));
    chk({name, "_flags"}, 32'(u_if.USR[5:2]), 32'(e.flags));
    chk({name, "_irq"}, 32'(u_if.irq), 32'd1);
    u_if.rbr_rd = 1'b1;
    @(negedge clk);
    u_if.rbr_rd = 1'b0;
    chk({name, "_cleared"}, 32'(u_if.USR[5:2]), 32'd0);
  endtask

  initial begin
    int   n, t, first_bad;
    logic bad;
    logic bit_bad[10];
    logic [7:0] bv;

    vecs[0] = '{8'hA5, 8'd2, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h00A5, 4'b0001};
    vecs[1] = '{8'h3C, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h003C, 4'b0001};
    vecs[2] = '{8'h81, 8'd1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0081, 4'b0001};
    vecs[3] = '{8'h5A, 8'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h005A, 4'b0101};
    vecs[4] = '{8'h7E, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h007E, 4'b1001};
    vecs[5] = '{8'hC3, 8'd3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'h00C3, 4'b0001};

    Ireset2     = 1'b0;
    u_if.THR    = '0;
    u_if.UCR    = '0;
    u_if.thr_wr = 1'b0;
    u_if.rbr_rd = 1'b0;
    rx_drv      = 1'b1;
    loop        = 1'b0;
    #1 Ireset2 = 1'b1;
    cycles(3);
    chk("reset_txd", 32'(txd), 32'd1);
    chk("reset_usr", 32'(u_if.USR), 32'h0003);
    chk("reset_rbr", 32'(u_if.RBR), 32'h0000);
    chk("reset_irq", 32'(u_if.irq), 32'd0);
    Ireset2 = 1'b0;
    cycles(2);

    // THRE with TXIE raises irq.
    u_if.UCR = 16'h0080;
    cycles(2);
    chk("irq_thre", 32'(u_if.irq), 32'd1);
    u_if.UCR = 16'h0000;
    cycles(2);
    chk("irq_off", 32'(u_if.irq), 32'd0);

    // Tx timing at DIV=0: 16 clk per bit.
    u_if.UCR = 16'h0001;
    thr_write(8'h55);
    n = 1;
    while (txd !== 1'b0 && n < 8) begin
      @(negedge clk);
      n++;
    end
    chk("tx_start_latency_le3", 32'(n <= 3), 32'd1);
    chk("tx_thre_loaded", 32'(u_if.USR[0]), 32'd1);
    chk("tx_busy", 32'(u_if.USR[6]), 32'd1);
    chk("tx_temt_mid", 32'(u_if.USR[1]), 32'd0);
    for (int b = 0; b < 10; b++) bit_bad[b] = 1'b0;
    for (int i = 0; i < 160; i++) begin
      if (txd !== frame_bit(8'h55, i / 16)) bit_bad[i/16] = 1'b1;
      @(negedge clk);
    end
    for (int b = 0; b < 10; b++) chk($sformatf("tx_bit%0d_bad", b), 32'(bit_bad[b]), 32'd0);
    chk("tx_temt_end", 32'(u_if.USR[1:0]), 32'd3);

    // Chaining: second write during the first frame, no idle gap.
    cycles(5);
    thr_write(8'h01);
    n = 0;
    while (txd !== 1'b0 && n < 8) begin
      @(negedge clk);
      n++;
    end
    chk("chain_start_seen", 32'(txd), 32'd0);
    bad = 1'b0;
    first_bad = -1;
    for (int i = 0; i < 320; i++) begin
      bv = (i < 160) ? 8'h01 : 8'h02;
      if (txd !== frame_bit(bv, (i % 160) / 16) && !bad) begin
        bad = 1'b1;
        first_bad = i;
      end
      if (i == 20) begin
        chk("chain_thre_1", 32'(u_if.USR[0]), 32'd1);
        u_if.THR    = 16'h0002;
        u_if.thr_wr = 1'b1;
      end
      if (i == 21) begin
        u_if.thr_wr = 1'b0;
        chk("chain_thre_0", 32'(u_if.USR[0]), 32'd0);
      end
      if (i == 170) chk("chain_thre_1_again", 32'(u_if.USR[0]), 32'd1);
      @(negedge clk);
    end
    chk("chain_waveform_first_bad", 32'(first_bad), 32'hFFFF_FFFF);
    cycles(10);
    u_if.UCR = 16'h0000;

    // Receive vectors: loopback or bench-driven line.
    for (int v = 0; v < 6; v++) begin
      exp_t e;
      u_if.UCR = {vecs[v].div, 4'b0100, vecs[v].podd, vecs[v].pen, 1'b1, vecs[v].lpbk};
      loop = vecs[v].lpbk;
      cycles(4);
      e.rbr   = vecs[v].exp_rbr;
      e.flags = vecs[v].exp_flags;
      sb.push_back(e);
      t = 16 * (int'(vecs[v].div) + 1);
      if (vecs[v].lpbk) begin
        thr_write(vecs[v].data);
        check_rx($sformatf("vec%0d", v), 13 * t + 100);
      end else begin
        send_rx(vecs[v].data, int'(vecs[v].div), vecs[v].pen, vecs[v].podd,
                vecs[v].bad_par, vecs[v].bad_stop);
        check_rx($sformatf("vec%0d", v), 4 * t);
      end
      cycles(4);
    end
    loop = 1'b0;

    // Overrun: two bytes without a read.
    u_if.UCR = 16'h0042;
    cycles(4);
    send_rx(8'h11, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    sb.push_back('{16'h0022, 4'b0011});
    send_rx(8'h22, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_rx("overrun", 64);

    // Glitch of 4 clk is rejected; the receiver then takes a real byte.
    rx_drv = 1'b0;
    cycles(4);
    rx_drv = 1'b1;
    cycles(40);
    chk("glitch_no_rdr", 32'(u_if.USR[2]), 32'd0);
    sb.push_back('{16'h0096, 4'b0001});
    send_rx(8'h96, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_rx("after_glitch", 64);

    // Asynchronous reset mid-frame, checked between clock edges.
    u_if.UCR = 16'h0001;
    thr_write(8'h00);
    cycles(30);
    chk("pre_reset_txd_low", 32'(txd), 32'd0);
    #2 Ireset2 = 1'b1;
    #1;
    chk("async_reset_txd", 32'(txd), 32'd1);
    chk("async_reset_usr", 32'(u_if.USR), 32'h0003);
    chk("async_reset_irq", 32'(u_if.irq), 32'd0);
    @(negedge clk);
    u_if.UCR = 16'h0000;
    Ireset2 = 1'b0;
    cycles(3);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
